// File: rtl/vmem_arbiter_if.sv
// Bundle of the VGA read port, the two pixel-writer ports, the memory port and FIFO status
// shared between the video-memory arbiter and its environment.
interface vmem_arbiter_if #(
    parameter int unsigned AW         = 19,
    parameter int unsigned DW         = 24,
    parameter int unsigned WBUF_DEPTH = 4
);
    localparam int unsigned CW = $clog2(WBUF_DEPTH) + 1;

    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_valid;
    logic [DW-1:0] rd_data;

    logic          w0_valid;
    logic          w0_ready;
    logic [AW-1:0] w0_addr;
    logic [DW-1:0] w0_data;

    logic          w1_valid;
    logic          w1_ready;
    logic [AW-1:0] w1_addr;
    logic [DW-1:0] w1_data;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic [CW-1:0] wbuf_count;
    logic          wbuf_empty;
    logic          wbuf_full;

    // Arbiter side.
    modport slave (
        input  rd_req, rd_addr,
        input  w0_valid, w0_addr, w0_data,
        input  w1_valid, w1_addr, w1_data,
        input  mem_rdata,
        output rd_valid, rd_data,
        output w0_ready, w1_ready,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output wbuf_count, wbuf_empty, wbuf_full
    );

    // Environment side: VGA reader, pixel writers and the memory itself.
    modport master (
        output rd_req, rd_addr,
        output w0_valid, w0_addr, w0_data,
        output w1_valid, w1_addr, w1_data,
        output mem_rdata,
        input  rd_valid, rd_data,
        input  w0_ready, w1_ready,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  wbuf_count, wbuf_empty, wbuf_full
    );
endinterface

// File: rtl/vmem_arbiter.sv
// Single-port video memory arbiter: fixed-latency reads with absolute priority, two writers
// merged round-robin into a posted-write FIFO that drains on read-free cycles.
module vmem_arbiter #(
    parameter int unsigned AW         = 19,
    parameter int unsigned DW         = 24,
    parameter int unsigned WBUF_DEPTH = 4
) (
    input logic           clk,
    input logic           resetn,
    vmem_arbiter_if.slave bus
);
    localparam int unsigned PW = $clog2(WBUF_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    entry_t        fifo_q [WBUF_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          last_grant_q, last_grant_d;

    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          rd_valid_q, rd_valid_d;

    logic   full;
    logic   empty;
    logic   gnt_vld;
    logic   gnt_sel;
    logic   push;
    logic   pop;
    entry_t push_entry;
    entry_t head;

    assign full  = (count_q == CW'(WBUF_DEPTH));
    assign empty = (count_q == '0);
    assign head  = fifo_q[rd_ptr_q];

    // Readies depend only on registered fullness, so a same-cycle pop never frees a slot.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_sel = 1'b0;
        if (resetn && !full) begin
            if (bus.w0_valid && bus.w1_valid) begin
                gnt_vld = 1'b1;
                gnt_sel = ~last_grant_q;
            end else if (bus.w0_valid) begin
                gnt_vld = 1'b1;
            end else if (bus.w1_valid) begin
                gnt_vld = 1'b1;
                gnt_sel = 1'b1;
            end
        end
    end

    assign bus.w0_ready = gnt_vld & ~gnt_sel;
    assign bus.w1_ready = gnt_vld & gnt_sel;
    assign push         = gnt_vld;
    assign push_entry   = gnt_sel ? {bus.w1_addr, bus.w1_data} : {bus.w0_addr, bus.w0_data};
    assign pop          = ~bus.rd_req & ~empty;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        last_grant_d = gnt_vld ? gnt_sel : last_grant_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        mem_en_d    = bus.rd_req | pop;
        mem_we_d    = pop;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (bus.rd_req) begin
            mem_addr_d = bus.rd_addr;
        end else if (pop) begin
            mem_addr_d  = head.addr;
            mem_wdata_d = head.data;
        end
        rd_valid_d = mem_en_q & ~mem_we_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            last_grant_q <= 1'b1;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rd_valid_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            last_grant_q <= last_grant_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

    // Entry storage needs no reset: pointers and count define which slots are live.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= push_entry;
    end

    assign bus.mem_en     = mem_en_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_data    = bus.mem_rdata;
    assign bus.wbuf_count = count_q;
    assign bus.wbuf_empty = empty;
    assign bus.wbuf_full  = full;
endmodule

// File: doc/vmem_arbiter.md
Name: vmem_arbiter

Overview:
- Shares the single-port synchronous video memory (19-bit address = {h_addr, v_addr[8:0]}, 24-bit RGB) between the VGA scan reader and two pixel writers (keyboard text renderer, UART image loader).
- Reads have absolute priority and fixed latency, so the VGA path never stalls.
- Writes are accepted into a shared posted-write FIFO with round-robin input arbitration. The FIFO drains into memory on any cycle with no read.

Parameters:
- AW, 19, memory address width
- DW, 24, pixel data width
- WBUF_DEPTH, 4, posted-write FIFO depth (power of two, ≥2)

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- rd_req  in  1  VGA read request, sampled every cycle
- rd_addr  in  AW  read address
- rd_valid  out  1  rd_data valid
- rd_data  out  DW  read pixel
- w0_valid  in  1  writer 0 request
- w0_ready  out  1  writer 0 accepted this cycle
- w0_addr  in  AW  writer 0 address
- w0_data  in  DW  writer 0 pixel
- w1_valid  in  1  writer 1 request
- w1_ready  out  1  writer 1 accepted this cycle
- w1_addr  in  AW  writer 1 address
- w1_data  in  DW  writer 1 pixel
- mem_en  out  1  memory access strobe (registered)
- mem_we  out  1  memory write enable (registered)
- mem_addr  out  AW  memory address (registered)
- mem_wdata  out  DW  memory write data (registered)
- mem_rdata  in  DW  memory read data, valid one cycle after mem_en with mem_we=0
- wbuf_count  out  clog2(WBUF_DEPTH)+1  FIFO occupancy
- wbuf_empty  out  1  wbuf_count==0
- wbuf_full  out  1  wbuf_count==WBUF_DEPTH

Behaviour:

Reset (resetn low, asynchronous):
- mem_en, mem_we, mem_addr, mem_wdata, rd_valid, w0_ready, w1_ready = 0.
- FIFO pointers and count = 0, so wbuf_empty=1 and wbuf_full=0.
- Round-robin last_grant = 1, so writer 0 wins first.
- Writes buffered when reset asserts are discarded; mid-flight reads are dropped and produce no rd_valid.

Read path:
- rd_req=1 in cycle t → mem_en=1, mem_we=0, mem_addr=rd_addr in t+1 → rd_valid=1 in t+2.
- rd_data is combinational from mem_rdata and is meaningful only while rd_valid=1.
- A read is never refused; back-to-back reads sustain one per cycle.

Drain:
- In cycle t with rd_req=0 and wbuf_count>0, the FIFO head is popped.
- In t+1: mem_en=1, mem_we=1, mem_addr/mem_wdata = head entry.
- With rd_req=0 and the FIFO empty: mem_en=0 and mem_we=0 in t+1.
- Writes reach memory in FIFO order.

Push arbitration (combinational, based on registered wbuf_full):
- If wbuf_full: both readies = 0. No push even if a pop happens the same cycle.
- Otherwise, with exactly one writer valid, that writer's ready = 1.
- With both valid, grant the writer ≠ last_grant; last_grant updates to the granted writer.
- At most one push per cycle. wx_ready may depend on wx_valid. An accepted entry is {addr, data}.

FIFO:
- Simultaneous push and pop allowed.
- Count update: +1 push only, −1 pop only, unchanged for both or neither.
- Pointers wrap modulo WBUF_DEPTH. Never overflows or underflows.

Hazard:
- No forwarding. A read of an address with a write still in the FIFO returns the old memory contents.
- Software uses wbuf_empty to synchronise.

Starvation:
- Writes wait indefinitely under continuous rd_req; this is acceptable because VGA blanking guarantees idle cycles.

Test Plan:
- Reset with resetn=0 while FIFO holds 3 entries → count 0, wbuf_empty=1, all outputs 0; release → no stale memory write is issued.
- rd_req=1, rd_addr=0x00123 at t → mem_en=1, mem_we=0, mem_addr=0x00123 at t+1; model returns 0xABCDEF → rd_valid=1, rd_data=0xABCDEF at t+2; 10 consecutive reads → 10 consecutive rd_valid.
- rd_req held 1, w0 writes 0x10..0x13 → w0_ready high 4 cycles, then wbuf_full=1 and w0_ready=0 with no mem_we; drop rd_req → 4 writes on mem_* in order, one per cycle, then wbuf_empty=1.
- w0 and w1 valid continuously, FIFO draining (rd_req=0) → grants alternate w0,w1,w0,w1…; memory write sequence alternates sources accordingly.
- Full FIFO, rd_req=0, both writers valid → that cycle: pop occurs, no push, count drops to DEPTH−1; next cycle a push is accepted.
- w0 writes addr 0x00055 = 0x112233 while rd_req=1, then read 0x00055 before drain → old value returned; after wbuf_empty=1 the read returns 0x112233.
